// File: rtl/t07_seq_pkg.sv
// t07_seq_pkg
//   Shared types and constants for the team 07 execution sequencer:
//   state encoding (also the debug state_o value), instruction op classes
//   and the FPUOp codes for the FPU load/store instructions.
package t07_seq_pkg;

    localparam logic [2:0] STATE_IDLE_ENC     = 3'd0;
    localparam logic [2:0] STATE_FETCH_ENC    = 3'd1;
    localparam logic [2:0] STATE_DECODE_ENC   = 3'd2;
    localparam logic [2:0] STATE_MEM_WAIT_ENC = 3'd3;
    localparam logic [2:0] STATE_FPU_WAIT_ENC = 3'd4;
    localparam logic [2:0] STATE_WB_ENC       = 3'd5;
    localparam logic [2:0] STATE_HALT_ENC     = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE     = STATE_IDLE_ENC,
        ST_FETCH    = STATE_FETCH_ENC,
        ST_DECODE   = STATE_DECODE_ENC,
        ST_MEM_WAIT = STATE_MEM_WAIT_ENC,
        ST_FPU_WAIT = STATE_FPU_WAIT_ENC,
        ST_WB       = STATE_WB_ENC,
        ST_HALT     = STATE_HALT_ENC
    } state_e;

    typedef enum logic [1:0] {
        OPC_ALU,
        OPC_MEM,
        OPC_FMEM,
        OPC_FPU
    } opclass_e;

    localparam logic [4:0] FPU_FLW = 5'd1;
    localparam logic [4:0] FPU_FSW = 5'd2;

    // FPU-class instructions that are really data-memory accesses.
    function automatic logic is_fpu_mem(input logic is_fpu, input logic [4:0] fpu_op);
        return is_fpu && (fpu_op == FPU_FLW || fpu_op == FPU_FSW);
    endfunction

endpackage

// File: rtl/t07_seq_timeout.sv
// t07_seq_timeout
//   Loadable up-counter used to bound the time spent waiting on the FPU.
//   Ports:
//     clk_i, rst_i  clock, synchronous active-high reset
//     clr_i         clear count to zero (priority over load/enable)
//     load_i        load load_val_i
//     load_val_i    value to load
//     en_i          count enable
//     tc_o          high while enabled and this cycle brings the count to FPU_TIMEOUT
module t07_seq_timeout #(
    parameter int unsigned FPU_TIMEOUT = 64,
    localparam int unsigned W = $clog2(FPU_TIMEOUT + 1)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         tc_o
);

    // The count is incremented at the end of the cycle, so the cycle that
    // makes it reach FPU_TIMEOUT is the one currently holding FPU_TIMEOUT-1.
    localparam logic [W-1:0] TC_VAL = W'(FPU_TIMEOUT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = en_i && (cnt_q == TC_VAL);

endmodule

// File: rtl/t07_exec_sequencer.sv
// t07_exec_sequencer
//   Multi-cycle instruction sequencer: FETCH -> DECODE -> (MEM_WAIT |
//   FPU_WAIT) -> WB, halting on illegal opcodes or an FPU timeout.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     run                      leave IDLE when high
//     instr_req/instr_ack      instruction fetch handshake; ir_load pulses on ack
//     mem_read..invalid_op     control-unit decode outputs, sampled in DECODE
//     data_req/data_rw/data_ack data memory handshake (data_rw 1 = write)
//     fpu_start/fpu_done       FPU start pulse and completion
//     pc_en, reg_we, fpu_reg_we one-cycle writeback strobes
//     illegal, timeout         sticky halt causes
//     state_o, retired         debug state and retired-instruction count
module t07_exec_sequencer
    import t07_seq_pkg::*;
#(
    parameter int unsigned FPU_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic             instr_req,
    input  logic             instr_ack,
    output logic             ir_load,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             reg_write,
    input  logic             is_fpu,
    input  logic [4:0]       fpu_op,
    input  logic [1:0]       fpu_write,
    input  logic             invalid_op,
    output logic             data_req,
    output logic             data_rw,
    input  logic             data_ack,
    output logic             fpu_start,
    input  logic             fpu_done,
    output logic             pc_en,
    output logic             reg_we,
    output logic             fpu_reg_we,
    output logic             illegal,
    output logic             timeout,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned TW = $clog2(FPU_TIMEOUT + 1);

    state_e           state_q, state_d;
    logic             wr_int_q, wr_int_d;
    logic             wr_fpu_q, wr_fpu_d;
    logic             rw_q, rw_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             fpu_entry_q;
    logic             tmo_tc;
    opclass_e         opc;

    logic instr_req_c, ir_load_c, data_req_c, data_rw_c, fpu_start_c;
    logic pc_en_c, reg_we_c, fpu_reg_we_c;

    t07_seq_timeout #(
        .FPU_TIMEOUT(FPU_TIMEOUT)
    ) u_timeout (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (state_q == ST_DECODE),
        .load_i     (1'b0),
        .load_val_i ({TW{1'b0}}),
        .en_i       (state_q == ST_FPU_WAIT),
        .tc_o       (tmo_tc)
    );

    always_comb begin
        state_d      = state_q;
        wr_int_d     = wr_int_q;
        wr_fpu_d     = wr_fpu_q;
        rw_d         = rw_q;
        illegal_d    = illegal_q;
        timeout_d    = timeout_q;
        retired_d    = retired_q;
        opc          = OPC_ALU;
        instr_req_c  = 1'b0;
        ir_load_c    = 1'b0;
        data_req_c   = 1'b0;
        data_rw_c    = 1'b0;
        fpu_start_c  = 1'b0;
        pc_en_c      = 1'b0;
        reg_we_c     = 1'b0;
        fpu_reg_we_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                instr_req_c = 1'b1;
                if (instr_ack) begin
                    ir_load_c = 1'b1;
                    state_d   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                wr_int_d = reg_write & ~is_fpu;
                wr_fpu_d = is_fpu & (|fpu_write);
                rw_d     = mem_write | (is_fpu & (fpu_op == FPU_FSW));
                if (mem_read || mem_write) begin
                    opc = OPC_MEM;
                end else if (is_fpu_mem(is_fpu, fpu_op)) begin
                    opc = OPC_FMEM;
                end else if (is_fpu) begin
                    opc = OPC_FPU;
                end
                if (invalid_op) begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end else begin
                    unique case (opc)
                        OPC_MEM, OPC_FMEM: state_d = ST_MEM_WAIT;
                        OPC_FPU:           state_d = ST_FPU_WAIT;
                        default:           state_d = ST_WB;
                    endcase
                end
            end
            ST_MEM_WAIT: begin
                data_req_c = 1'b1;
                data_rw_c  = rw_q;
                if (data_ack) state_d = ST_WB;
            end
            ST_FPU_WAIT: begin
                fpu_start_c = fpu_entry_q;
                // A done arriving on the terminal cycle still completes.
                if (fpu_done) begin
                    state_d = ST_WB;
                end else if (tmo_tc) begin
                    state_d   = ST_HALT;
                    timeout_d = 1'b1;
                end
            end
            ST_WB: begin
                pc_en_c      = 1'b1;
                reg_we_c     = wr_int_q;
                fpu_reg_we_c = wr_fpu_q;
                retired_d    = retired_q + CNT_W'(1);
                state_d      = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_int_q    <= 1'b0;
            wr_fpu_q    <= 1'b0;
            rw_q        <= 1'b0;
            illegal_q   <= 1'b0;
            timeout_q   <= 1'b0;
            retired_q   <= '0;
            fpu_entry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_int_q    <= wr_int_d;
            wr_fpu_q    <= wr_fpu_d;
            rw_q        <= rw_d;
            illegal_q   <= illegal_d;
            timeout_q   <= timeout_d;
            retired_q   <= retired_d;
            fpu_entry_q <= (state_q == ST_DECODE);
        end
    end

    // Outputs are forced low while rst is asserted, even before the first
    // reset edge has returned the state register to IDLE.
    assign instr_req  = instr_req_c  & ~rst;
    assign ir_load    = ir_load_c    & ~rst;
    assign data_req   = data_req_c   & ~rst;
    assign data_rw    = data_rw_c    & ~rst;
    assign fpu_start  = fpu_start_c  & ~rst;
    assign pc_en      = pc_en_c      & ~rst;
    assign reg_we     = reg_we_c     & ~rst;
    assign fpu_reg_we = fpu_reg_we_c & ~rst;
    assign illegal    = illegal_q    & ~rst;
    assign timeout    = timeout_q    & ~rst;
    assign state_o    = rst ? 3'd0 : state_q;
    assign retired    = rst ? '0 : retired_q;

endmodule

// File: tb/tb_t07_exec_sequencer.sv
// tb_t07_exec_sequencer
//   Directed bench for t07_exec_sequencer with FPU_TIMEOUT=4. Inputs change
//   on the falling edge; outputs are sampled 1 time unit later.
module tb_t07_exec_sequencer;

    logic        clk = 1'b0;
    logic        rst, run, instr_ack, mem_read, mem_write, reg_write, is_fpu;
    logic [4:0]  fpu_op;
    logic [1:0]  fpu_write;
    logic        invalid_op, data_ack, fpu_done;
    logic        instr_req, ir_load, data_req, data_rw, fpu_start, pc_en;
    logic        reg_we, fpu_reg_we, illegal, timeout;
    logic [2:0]  state_o;
    logic [31:0] retired;
    logic [9:0]  outs;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] exp_ret = '0;

    always #5 clk = ~clk;

    // {instr_req, ir_load, data_req, data_rw, fpu_start, pc_en, reg_we, fpu_reg_we, illegal, timeout}
    assign outs = {instr_req, ir_load, data_req, data_rw, fpu_start,
                   pc_en, reg_we, fpu_reg_we, illegal, timeout};

    t07_exec_sequencer #(
        .FPU_TIMEOUT(4),
        .CNT_W(32)
    ) dut (
        .clk(clk), .rst(rst), .run(run),
        .instr_req(instr_req), .instr_ack(instr_ack), .ir_load(ir_load),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .is_fpu(is_fpu), .fpu_op(fpu_op), .fpu_write(fpu_write),
        .invalid_op(invalid_op),
        .data_req(data_req), .data_rw(data_rw), .data_ack(data_ack),
        .fpu_start(fpu_start), .fpu_done(fpu_done),
        .pc_en(pc_en), .reg_we(reg_we), .fpu_reg_we(fpu_reg_we),
        .illegal(illegal), .timeout(timeout),
        .state_o(state_o), .retired(retired)
    );

    task automatic set_ctrl(input logic mr, input logic mw, input logic rw,
                            input logic fp, input logic [4:0] op,
                            input logic [1:0] fw, input logic inv);
        mem_read = mr; mem_write = mw; reg_write = rw; is_fpu = fp;
        fpu_op = op; fpu_write = fw; invalid_op = inv;
    endtask

    // Pulse reset and return at the falling edge of the first FETCH cycle.
    task automatic restart();
        rst = 1'b1; run = 1'b1;
        {instr_ack, data_ack, fpu_done} = 3'b000;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_ret = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (outs !== 10'b0 || state_o !== 3'd0 || retired !== 32'd0) begin
            errors++;
            $display("FAIL reset_held: state=%0d outs=%b retired=%0d, expected 0/0/0", state_o, outs, retired);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (outs !== 10'b0 || state_o !== 3'd0) begin
            errors++;
            $display("FAIL reset_release: state=%0d outs=%b, expected state=0 outs=0", state_o, outs);
        end
        @(negedge clk);
        #1;
        checks++;
        if (outs !== 10'b1000000000 || state_o !== 3'd1) begin
            errors++;
            $display("FAIL reset_fetch: state=%0d outs=%b, expected state=1 outs=1000000000", state_o, outs);
        end
        @(negedge clk);
    endtask

    task automatic test_alu();
        logic [2:0] ack [3] = '{3'b100, 3'b000, 3'b000};
        logic [2:0] st  [3] = '{3'd1, 3'd2, 3'd5};
        logic [9:0] ou  [3] = '{10'b1100000000, 10'b0000000000, 10'b0000011000};
        set_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 2'd0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            {instr_ack, data_ack, fpu_done} = ack[c];
            #1;
            checks++;
            if (state_o !== st[c] || outs !== ou[c]) begin
                errors++;
                $display("FAIL alu c%0d: state=%0d outs=%b, expected state=%0d outs=%b", c, state_o, outs, st[c], ou[c]);
            end
            @(negedge clk);
        end
        {instr_ack, data_ack, fpu_done} = 3'b000;
        exp_ret = exp_ret + 32'd1;
        #1;
        checks++;
        if (retired !== exp_ret || state_o !== 3'd1) begin
            errors++;
            $display("FAIL alu_retire: retired=%0d state=%0d, expected retired=%0d state=1", retired, state_o, exp_ret);
        end
    endtask

    task automatic test_store();
        logic [2:0] ack [6] = '{3'b100, 3'b010, 3'b000, 3'b000, 3'b010, 3'b000};
        logic [2:0] st  [6] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd5};
        logic [9:0] ou  [6] = '{10'b1100000000, 10'b0000000000, 10'b0011000000,
                                10'b0011000000, 10'b0011000000, 10'b0000010000};
        set_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
        run = 1'b0;
        for (int c = 0; c < 6; c++) begin
            {instr_ack, data_ack, fpu_done} = ack[c];
            #1;
            checks++;
            if (state_o !== st[c] || outs !== ou[c]) begin
                errors++;
                $display("FAIL store c%0d: state=%0d outs=%b, expected state=%0d outs=%b", c, state_o, outs, st[c], ou[c]);
            end
            @(negedge clk);
        end
        {instr_ack, data_ack, fpu_done} = 3'b000;
        run = 1'b1;
        exp_ret = exp_ret + 32'd1;
        #1;
        checks++;
        if (retired !== exp_ret || state_o !== 3'd1) begin
            errors++;
            $display("FAIL store_retire: retired=%0d state=%0d, expected retired=%0d state=1", retired, state_o, exp_ret);
        end
    endtask

    task automatic test_fsw();
        logic [2:0] ack [4] = '{3'b100, 3'b000, 3'b010, 3'b000};
        logic [2:0] st  [4] = '{3'd1, 3'd2, 3'd3, 3'd5};
        logic [9:0] ou  [4] = '{10'b1100000000, 10'b0000000000, 10'b0011000000, 10'b0000010000};
        set_ctrl(1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 2'd0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            {instr_ack, data_ack, fpu_done} = ack[c];
            #1;
            checks++;
            if (state_o !== st[c] || outs !== ou[c]) begin
                errors++;
                $display("FAIL fsw c%0d: state=%0d outs=%b, expected state=%0d outs=%b", c, state_o, outs, st[c], ou[c]);
            end
            @(negedge clk);
        end
        {instr_ack, data_ack, fpu_done} = 3'b000;
        exp_ret = exp_ret + 32'd1;
    endtask

    task automatic test_load();
        logic [2:0] ack [4] = '{3'b100, 3'b000, 3'b010, 3'b000};
        logic [2:0] st  [4] = '{3'd1, 3'd2, 3'd3, 3'd5};
        logic [9:0] ou  [4] = '{10'b1100000000, 10'b0000000000, 10'b0010000000, 10'b0000011000};
        set_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 2'd0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            {instr_ack, data_ack, fpu_done} = ack[c];
            #1;
            checks++;
            if (state_o !== st[c] || outs !== ou[c]) begin
                errors++;
                $display("FAIL load c%0d: state=%0d outs=%b, expected state=%0d outs=%b", c, state_o, outs, st[c], ou[c]);
            end
            @(negedge clk);
        end
        {instr_ack, data_ack, fpu_done} = 3'b000;
        exp_ret = exp_ret + 32'd1;
    endtask

    task automatic test_fpu();
        logic [2:0] ack [7] = '{3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000};
        logic [2:0] st  [7] = '{3'd1, 3'd2, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5};
        logic [9:0] ou  [7] = '{10'b1100000000, 10'b0000000000, 10'b0000100000, 10'b0000000000,
                                10'b0000000000, 10'b0000000000, 10'b0000010100};
        set_ctrl(1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 2'd1, 1'b0);
        for (int c = 0; c < 7; c++) begin
            {instr_ack, data_ack, fpu_done} = ack[c];
            #1;
            checks++;
            if (state_o !== st[c] || outs !== ou[c]) begin
                errors++;
                $display("FAIL fpu c%0d: state=%0d outs=%b, expected state=%0d outs=%b", c, state_o, outs, st[c], ou[c]);
            end
            @(negedge clk);
        end
        {instr_ack, data_ack, fpu_done} = 3'b000;
        exp_ret = exp_ret + 32'd1;
    endtask

    task automatic test_fpu_fast();
        logic [2:0] ack [4] = '{3'b100, 3'b000, 3'b001, 3'b000};
        logic [2:0] st  [4] = '{3'd1, 3'd2, 3'd4, 3'd5};
        logic [9:0] ou  [4] = '{10'b1100000000, 10'b0000000000, 10'b0000100000, 10'b0000010100};
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 2'd2, 1'b0);
        for (int c = 0; c < 4; c++) begin
            {instr_ack, data_ack, fpu_done} = ack[c];
            #1;
            checks++;
            if (state_o !== st[c] || outs !== ou[c]) begin
                errors++;
                $display("FAIL fpu_fast c%0d: state=%0d outs=%b, expected state=%0d outs=%b", c, state_o, outs, st[c], ou[c]);
            end
            @(negedge clk);
        end
        {instr_ack, data_ack, fpu_done} = 3'b000;
        exp_ret = exp_ret + 32'd1;
        #1;
        checks++;
        if (retired !== exp_ret || state_o !== 3'd1) begin
            errors++;
            $display("FAIL fpu_retire: retired=%0d state=%0d, expected retired=%0d state=1", retired, state_o, exp_ret);
        end
    endtask

    task automatic test_illegal();
        logic [2:0] ack [4] = '{3'b100, 3'b000, 3'b111, 3'b111};
        logic [2:0] st  [4] = '{3'd1, 3'd2, 3'd6, 3'd6};
        logic [9:0] ou  [4] = '{10'b1100000000, 10'b0000000000, 10'b0000000010, 10'b0000000010};
        set_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 2'd0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            {instr_ack, data_ack, fpu_done} = ack[c];
            #1;
            checks++;
            if (state_o !== st[c] || outs !== ou[c]) begin
                errors++;
                $display("FAIL illegal c%0d: state=%0d outs=%b, expected state=%0d outs=%b", c, state_o, outs, st[c], ou[c]);
            end
            @(negedge clk);
        end
        {instr_ack, data_ack, fpu_done} = 3'b000;
        #1;
        checks++;
        if (retired !== exp_ret || state_o !== 3'd6) begin
            errors++;
            $display("FAIL illegal_retire: retired=%0d state=%0d, expected retired=%0d state=6", retired, state_o, exp_ret);
        end
    endtask

    task automatic test_timeout();
        logic [2:0] ack [9] = '{3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b111, 3'b111};
        logic [2:0] st  [9] = '{3'd1, 3'd2, 3'd4, 3'd4, 3'd4, 3'd4, 3'd6, 3'd6, 3'd6};
        logic [9:0] ou  [9] = '{10'b1100000000, 10'b0000000000, 10'b0000100000, 10'b0000000000,
                                10'b0000000000, 10'b0000000000, 10'b0000000001, 10'b0000000001,
                                10'b0000000001};
        restart();
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 2'd1, 1'b0);
        for (int c = 0; c < 9; c++) begin
            {instr_ack, data_ack, fpu_done} = ack[c];
            #1;
            checks++;
            if (state_o !== st[c] || outs !== ou[c]) begin
                errors++;
                $display("FAIL timeout c%0d: state=%0d outs=%b, expected state=%0d outs=%b", c, state_o, outs, st[c], ou[c]);
            end
            @(negedge clk);
        end
        {instr_ack, data_ack, fpu_done} = 3'b000;
        #1;
        checks++;
        if (retired !== exp_ret) begin
            errors++;
            $display("FAIL timeout_retire: retired=%0d, expected %0d", retired, exp_ret);
        end
    endtask

    task automatic test_rst_midop();
        restart();
        set_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 2'd0, 1'b0);
        instr_ack = 1'b1;
        @(negedge clk);
        instr_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (state_o !== 3'd3 || outs !== 10'b0010000000) begin
            errors++;
            $display("FAIL midop_wait: state=%0d outs=%b, expected state=3 outs=0010000000", state_o, outs);
        end
        rst = 1'b1; data_ack = 1'b1;
        #1;
        checks++;
        if (state_o !== 3'd0 || outs !== 10'b0 || retired !== 32'd0) begin
            errors++;
            $display("FAIL midop_rst: state=%0d outs=%b retired=%0d, expected 0/0/0", state_o, outs, retired);
        end
        @(negedge clk);
        rst = 1'b0; run = 1'b0;
        #1;
        checks++;
        if (state_o !== 3'd0 || outs !== 10'b0) begin
            errors++;
            $display("FAIL midop_idle: state=%0d outs=%b, expected state=0 outs=0", state_o, outs);
        end
        @(negedge clk);
        #1;
        checks++;
        if (state_o !== 3'd0 || outs !== 10'b0) begin
            errors++;
            $display("FAIL midop_norun: state=%0d outs=%b, expected state=0 outs=0", state_o, outs);
        end
        run = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (state_o !== 3'd1 || outs !== 10'b1000000000) begin
            errors++;
            $display("FAIL midop_refetch: state=%0d outs=%b, expected state=1 outs=1000000000", state_o, outs);
        end
        data_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; run = 1'b1;
        {instr_ack, data_ack, fpu_done} = 3'b000;
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
        test_reset();
        test_alu();
        test_store();
        test_fsw();
        test_load();
        test_fpu();
        test_fpu_fast();
        test_illegal();
        test_timeout();
        test_rst_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/t07_exec_sequencer.md
Name: t07_exec_sequencer

Overview:
- Multi-cycle instruction sequencer for the team 07 core. It sits between the instruction/data memory handler, the control-unit decode outputs, the FPU and the register files.
- Steps each instruction through fetch, decode, execute-wait and writeback.
- Stalls for memory acknowledges and multi-cycle FPU ops.
- Issues one-cycle PC-advance and register-write pulses.
- Halts on illegal opcodes or an FPU timeout.

Parameters:
- FPU_TIMEOUT, 64, maximum cycles spent in FPU_WAIT without fpu_done before halting.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- run  in  1  level; leaves IDLE when 1
- instr_req  out  1  instruction fetch request
- instr_ack  in  1  fetch data valid; same-cycle acknowledge allowed
- ir_load  out  1  one-cycle pulse; latch the instruction register
- mem_read  in  1  control-unit memRead
- mem_write  in  1  control-unit memWrite
- reg_write  in  1  control-unit regWrite
- is_fpu  in  1  control-unit memSrc; 1 means FPU-class instruction
- fpu_op  in  5  control-unit FPUOp
- fpu_write  in  2  control-unit FPUWrite
- invalid_op  in  1  control-unit invalid_Op
- data_req  out  1  data memory request
- data_rw  out  1  1 = write, 0 = read; valid while data_req is high
- data_ack  in  1  data access complete
- fpu_start  out  1  one-cycle FPU start pulse
- fpu_done  in  1  FPU result valid
- pc_en  out  1  one-cycle PC advance pulse
- reg_we  out  1  gated integer register-file write pulse
- fpu_reg_we  out  1  gated FPU register-file write pulse
- illegal  out  1  sticky; illegal opcode seen
- timeout  out  1  sticky; FPU timeout occurred
- state_o  out  3  current state, for debug
- retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset: synchronous and active-high.
  - Every output is 0 while rst=1 and in the cycle after rst drops; this includes illegal, timeout and retired.
  - State goes to IDLE.
  - Reset has priority over everything and aborts any in-flight operation. Any outstanding ack after reset is ignored.
- States are IDLE, FETCH, DECODE, MEM_WAIT, FPU_WAIT, WB, HALT. Outputs are Moore (decoded from state) except where noted.
- IDLE:
  - All outputs low.
  - run=1 -> FETCH.
- FETCH:
  - instr_req=1.
  - On instr_ack=1: ir_load=1 in that same cycle, then -> DECODE.
  - run has no effect once left IDLE.
- DECODE: one cycle. Control inputs are sampled and latched into the op class and flags (wr_int, wr_fpu, rw). Priority, highest first:
  - invalid_op=1 -> HALT, illegal<=1.
  - mem_read|mem_write, or is_fpu with fpu_op 1 (FLW) or 2 (FSW) -> MEM_WAIT.
    - rw latched as mem_write | (is_fpu & fpu_op==2).
  - is_fpu=1 (any other fpu_op) -> FPU_WAIT.
  - Otherwise -> WB.
- MEM_WAIT:
  - data_req=1 and data_rw=rw, held until data_ack.
  - On data_ack -> WB.
  - data_ack seen outside MEM_WAIT is ignored.
- FPU_WAIT:
  - fpu_start=1 on the entry cycle only.
  - Cycle counter cleared on entry and incremented each cycle.
  - fpu_done is accepted in any FPU_WAIT cycle, including the entry cycle -> WB.
  - If the counter reaches FPU_TIMEOUT with no fpu_done -> HALT, timeout<=1.
  - fpu_done in the same cycle the counter reaches FPU_TIMEOUT: done wins -> WB.
- WB: one cycle, then -> FETCH.
  - pc_en=1.
  - reg_we = latched reg_write & ~is_fpu.
  - fpu_reg_we = latched is_fpu & (fpu_write!=0).
  - retired<=retired+1, wrapping to 0 at all-ones.
- HALT:
  - Absorbing until rst.
  - All strobes 0; illegal and timeout hold their values.
- Latency with same-cycle acks:
  - ALU op: 3 cycles, FETCH -> DECODE -> WB.
  - Memory op: 4 cycles plus data wait cycles.
  - FPU op: 4 cycles plus FPU latency.
  - PC advances exactly once per retired instruction.
- Control inputs need to be valid only in DECODE; later changes have no effect.
- state_o encoding: IDLE 0, FETCH 1, DECODE 2, MEM_WAIT 3, FPU_WAIT 4, WB 5, HALT 6.

Decomposition:
- Package t07_seq_pkg holds:
  - state enum (3-bit, encoding above);
  - op-class enum: OPC_ALU, OPC_MEM, OPC_FMEM, OPC_FPU;
  - FPUOp constants FPU_FLW=5'd1, FPU_FSW=5'd2;
  - state_o encoding constants.
- One sub-module, t07_seq_timeout:
  - loadable up-counter with clear, enable and terminal-count flag;
  - parameter FPU_TIMEOUT, width $clog2(FPU_TIMEOUT+1).

Test Plan:
- Reset/IDLE: rst=1 for 2 cycles with run=1 -> all outputs 0, state_o=0. After rst drops -> state_o=1, instr_req=1.
- ALU op: instr_ack on the first FETCH cycle; decode reg_write=1, is_fpu=0 -> ir_load, then DECODE, then WB with pc_en=1 and reg_we=1. retired=1. Next cycle is FETCH.
- Store with 3-cycle data wait: mem_write=1, data_ack on the 3rd MEM_WAIT cycle -> data_req high for 3 cycles, data_rw=1, reg_we=0, pc_en pulses once. FSW (is_fpu=1, fpu_op=2) behaves the same with data_rw=1.
- FPU op: fpu_op=7, fpu_write=1, fpu_done after 5 cycles -> fpu_start exactly 1 cycle, fpu_reg_we=1 in WB, reg_we=0. Repeat with fpu_done on the entry cycle -> total latency 4 cycles.
- FPU timeout with FPU_TIMEOUT=4: no fpu_done -> HALT after 4 FPU_WAIT cycles, timeout=1, no pc_en, stays halted under further acks until rst.
- Illegal op: invalid_op=1 in DECODE -> HALT, illegal=1, retired unchanged. rst mid-MEM_WAIT clears all outputs and returns to IDLE.
